perf_counter_bank: RTL and testbench
====================================

# perf_counter_bank

Parametrised bank of hardware performance counters for the RV32I pipelined core. It counts pipeline and cache events such as branch mispredictions, branches/jumps, cache requests and physical-memory accesses. It also supports atomic snapshot, read-and-clear, sticky overflow and a request/response readout port. It sits beside the datapath and cache hierarchy inside the CPU. A bench or debug unit reads it, so measurement no longer depends on testbench-side hierarchical counting.

## Interface
Parameters:
- NUM_CNT, 8, number of counter channels (1..32)
- CNT_WIDTH, 32, width of each counter (8..64)
- SATURATE, 0, 0 = wrap to 0 on overflow, 1 = hold at all-ones on overflow
- SEL_W, $clog2(NUM_CNT) (min 1), width of rd_sel

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- event_i  in  NUM_CNT  per-channel event input
- mode_i  in  NUM_CNT  per-channel mode: 0 = level (count every cycle event high), 1 = edge (count 0->1 transitions)
- enable  in  1  global count enable
- clear  in  1  zero all live counters and live overflow flags
- snapshot  in  1  copy all live counters and overflow flags into shadow registers
- rd_read  in  1  read request; held high until rd_resp
- rd_sel  in  SEL_W  channel to read; sampled when request accepted
- rd_resp  out  1  one-cycle response pulse
- rd_rdata  out  CNT_WIDTH  shadow counter value of selected channel
- rd_overflow  out  1  shadow overflow flag of selected channel
- overflow  out  NUM_CNT  live sticky overflow flags

## Operation
- Per channel i, the increment is computed as follows:
  - inc_i = enable & (mode_i[i] ? (event_i[i] & ~prev_i[i]) : event_i[i]).
  - prev_i is registered every cycle regardless of enable.
- Counting:
  - If inc_i is set and cnt_i != all-ones, cnt_i <= cnt_i + 1.
  - If inc_i is set and cnt_i == all-ones, cnt_i <= SATURATE ? all-ones : 0, and ovf_i <= 1. The overflow flag is sticky.
- clear: cnt_i <= 0 and ovf_i <= 0 for all i. This overrides any same-cycle increment, and that event is lost. prev_i still updates.
- snapshot: shadow_cnt_i <= cnt_i and shadow_ovf_i <= ovf_i, using pre-update register values.
  - snapshot+clear in the same cycle is read-and-clear: the shadows get the old values and the live counters go to 0.
  - clear alone does not touch the shadows.
- Read FSM, states IDLE and RESP:
  - IDLE: if rd_read is high, latch rd_rdata <= shadow_cnt[rd_sel] and rd_overflow <= shadow_ovf[rd_sel], then go to RESP.
  - If rd_sel >= NUM_CNT, latch 0/0.
  - RESP: rd_resp = 1 for exactly one cycle, then return to IDLE unconditionally.
  - The requester must drop rd_read in the cycle after rd_resp. If rd_read is still high in IDLE, a new read starts.
- rd_rdata and rd_overflow hold their value between reads. A snapshot while in RESP does not alter the data being returned.

## Timing
- Reset (rst == 0 at a clock edge) sets all counters, shadows, ovf, shadow_ovf, prev, rd_rdata, rd_overflow, overflow and rd_resp to 0, and the FSM to IDLE.
  - Reset mid-read: rd_resp is 0 from the next cycle and the read is dropped.
- Count latency: an event at edge N is visible in cnt/overflow after edge N. It reaches rd_rdata only after a later snapshot.
- Read latency: rd_read is sampled at edge N in IDLE, and rd_resp/rd_rdata are valid in cycle N+1.
  - Maximum read throughput is one read per 2 cycles.
- overflow output is registered and updates in the same cycle as the wrapping increment.
- Edge mode: a high level held across enable 0->1 does not count. An event already high before reset release counts only after it goes low and then high again.

## Test plan
- Level mode, ch0 event high for 10 cycles with enable=1, then snapshot, then read sel=0 -> rd_resp one cycle after request, rd_rdata=10, rd_overflow=0.
- Edge mode, ch1 event pattern 1,1,0,1,0,1,1 -> snapshot/read gives 3. Same pattern with enable=0 gives 0.
- CNT_WIDTH=8, SATURATE=0, 257 level events -> cnt=1, overflow[ch]=1. With SATURATE=1 the same stimulus gives cnt=255, overflow=1.
- Read-and-clear:
  - Count ch2 to 5, assert snapshot+clear together, and send an event in the same cycle -> shadow=5, live=0, the event is not counted.
  - A following snapshot/read gives 0.
- Read handshake edge cases:
  - rd_sel=NUM_CNT -> rdata=0, rd_overflow=0.
  - Snapshot asserted during RESP -> returned data unchanged.
  - rd_read held 4 cycles -> two responses, 2 cycles apart.
- Reset: assert rst=0 while in RESP with counters nonzero -> next cycle rd_resp=0 and all outputs/counters 0. After release, the first read returns 0.

Source files
------------

// File: rtl/perf_counter_bank.sv
// Performance counter bank: per-channel level/edge event counters with sticky overflow,
// atomic snapshot into shadow registers and a two-state request/response readout port.
module perf_counter_bank #(
    parameter int unsigned NUM_CNT   = 8,
    parameter int unsigned CNT_WIDTH = 32,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned SEL_W     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CNT-1:0]   event_i,
    input  logic [NUM_CNT-1:0]   mode_i,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 snapshot,
    input  logic                 rd_read,
    input  logic [SEL_W-1:0]     rd_sel,
    output logic                 rd_resp,
    output logic [CNT_WIDTH-1:0] rd_rdata,
    output logic                 rd_overflow,
    output logic [NUM_CNT-1:0]   overflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rd_state_e;

    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_q;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_d;
    logic [NUM_CNT-1:0][CNT_WIDTH-1:0] shadow_cnt_q;
    logic [NUM_CNT-1:0]                ovf_q;
    logic [NUM_CNT-1:0]                ovf_d;
    logic [NUM_CNT-1:0]                shadow_ovf_q;
    logic [NUM_CNT-1:0]                prev_q;
    logic [NUM_CNT-1:0]                arm_q;
    logic [NUM_CNT-1:0]                inc_c;

    rd_state_e                         state_q;
    logic                              rd_resp_q;
    logic [CNT_WIDTH-1:0]              rd_rdata_q;
    logic                              rd_ovf_q;
    logic [CNT_WIDTH-1:0]              sel_cnt_c;
    logic                              sel_ovf_c;

    // Next counter/overflow values; clear wins over a same-cycle increment.
    // arm_q blocks an edge-mode count until the event has been seen low since reset.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        inc_c = '0;
        for (int i = 0; i < int'(NUM_CNT); i++) begin
            inc_c[i] = enable & (mode_i[i] ? (event_i[i] & ~prev_q[i] & arm_q[i]) : event_i[i]);
            if (clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (inc_c[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    cnt_d[i] = SATURATE ? CNT_MAX : '0;
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q        <= '0;
            ovf_q        <= '0;
            shadow_cnt_q <= '0;
            shadow_ovf_q <= '0;
            prev_q       <= '0;
            arm_q        <= ~event_i;
        end else begin
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            prev_q <= event_i;
            arm_q  <= arm_q | ~event_i;
            if (snapshot) begin
                shadow_cnt_q <= cnt_q;
                shadow_ovf_q <= ovf_q;
            end
        end
    end

    // Shadow read mux; an out-of-range select returns zero.
    always_comb begin
        sel_cnt_c = '0;
        sel_ovf_c = 1'b0;
        for (int i = 0; i < int'(NUM_CNT); i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_cnt_c = shadow_cnt_q[i];
                sel_ovf_c = shadow_ovf_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rd_resp_q  <= 1'b0;
            rd_rdata_q <= '0;
            rd_ovf_q   <= 1'b0;
        end else begin
            rd_resp_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_read) begin
                        rd_rdata_q <= sel_cnt_c;
                        rd_ovf_q   <= sel_ovf_c;
                        rd_resp_q  <= 1'b1;
                        state_q    <= ST_RESP;
                    end
                end
                ST_RESP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rd_resp     = rd_resp_q;
    assign rd_rdata    = rd_rdata_q;
    assign rd_overflow = rd_ovf_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: wrapping and saturating instances driven in parallel,
// checked against constant vectors, directed sequences and a per-cycle reference model.
`timescale 1ns/1ps
module tb_perf_counter_bank;

    localparam int unsigned NC   = 6;
    localparam int unsigned CW   = 8;
    localparam int unsigned SW   = 3;
    localparam int          MAXV = 255;

    logic          clk;
    logic          rst;
    logic [NC-1:0] ev;
    logic [NC-1:0] md;
    logic          en;
    logic          clr;
    logic          snap;
    logic          rrd;
    logic [SW-1:0] sel;

    logic          resp_w, resp_s, rovf_w, rovf_s;
    logic [CW-1:0] rdat_w, rdat_s;
    logic [NC-1:0] ovf_w, ovf_s;

    int n_cmp;
    int n_err;
    bit chk_on;

    perf_counter_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .SATURATE(1'b0), .SEL_W(SW)) u_wrap (
        .clk(clk), .rst(rst), .event_i(ev), .mode_i(md), .enable(en), .clear(clr),
        .snapshot(snap), .rd_read(rrd), .rd_sel(sel), .rd_resp(resp_w),
        .rd_rdata(rdat_w), .rd_overflow(rovf_w), .overflow(ovf_w)
    );

    perf_counter_bank #(.NUM_CNT(NC), .CNT_WIDTH(CW), .SATURATE(1'b1), .SEL_W(SW)) u_sat (
        .clk(clk), .rst(rst), .event_i(ev), .mode_i(md), .enable(en), .clear(clr),
        .snapshot(snap), .rd_read(rrd), .rd_sel(sel), .rd_resp(resp_s),
        .rd_rdata(rdat_s), .rd_overflow(rovf_s), .overflow(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: index 0 = wrapping bank, 1 = saturating bank.
    int m_cnt  [2][NC];
    bit m_ovf  [2][NC];
    int m_sh   [2][NC];
    bit m_sho  [2][NC];
    bit m_prev [NC];
    bit m_seen_low [NC];
    bit m_busy;
    bit m_resp;
    int m_rdat [2];
    bit m_rovf [2];

    function automatic void model_step();
        bit hit;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NC; i++) begin
                    m_cnt[k][i] = 0; m_ovf[k][i] = 0; m_sh[k][i] = 0; m_sho[k][i] = 0;
                end
                m_rdat[k] = 0; m_rovf[k] = 0;
            end
            for (int i = 0; i < NC; i++) begin
                m_prev[i] = 0;
                m_seen_low[i] = !ev[i];
            end
            m_busy = 0; m_resp = 0;
        end else begin
            m_resp = 0;
            if (m_busy) m_busy = 0;
            else if (rrd) begin
                m_busy = 1; m_resp = 1;
                for (int k = 0; k < 2; k++) begin
                    if (int'(sel) < NC) begin
                        m_rdat[k] = m_sh[k][int'(sel)];
                        m_rovf[k] = m_sho[k][int'(sel)];
                    end else begin
                        m_rdat[k] = 0; m_rovf[k] = 0;
                    end
                end
            end
            if (snap) begin
                for (int k = 0; k < 2; k++)
                    for (int i = 0; i < NC; i++) begin
                        m_sh[k][i] = m_cnt[k][i]; m_sho[k][i] = m_ovf[k][i];
                    end
            end
            for (int i = 0; i < NC; i++) begin
                if (md[i]) hit = en && ev[i] && !m_prev[i] && m_seen_low[i];
                else       hit = en && ev[i];
                for (int k = 0; k < 2; k++) begin
                    if (clr) begin
                        m_cnt[k][i] = 0; m_ovf[k][i] = 0;
                    end else if (hit) begin
                        if (m_cnt[k][i] + 1 > MAXV) m_ovf[k][i] = 1;
                        if (k == 0) m_cnt[k][i] = (m_cnt[k][i] + 1) % (MAXV + 1);
                        else        m_cnt[k][i] = (m_cnt[k][i] + 1 > MAXV) ? MAXV : m_cnt[k][i] + 1;
                    end
                end
                m_prev[i] = ev[i];
                if (!ev[i]) m_seen_low[i] = 1;
            end
        end
    endfunction

    function automatic void chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void compare_all();
        logic [NC-1:0] eo_w, eo_s;
        for (int i = 0; i < NC; i++) begin
            eo_w[i] = m_ovf[0][i];
            eo_s[i] = m_ovf[1][i];
        end
        chk("model_resp_w", longint'(resp_w), longint'(m_resp));
        chk("model_resp_s", longint'(resp_s), longint'(m_resp));
        chk("model_rdata_w", longint'(rdat_w), longint'(m_rdat[0]));
        chk("model_rdata_s", longint'(rdat_s), longint'(m_rdat[1]));
        chk("model_rovf_w", longint'(rovf_w), longint'(m_rovf[0]));
        chk("model_rovf_s", longint'(rovf_s), longint'(m_rovf[1]));
        chk("model_overflow_w", longint'(ovf_w), longint'(eo_w));
        chk("model_overflow_s", longint'(ovf_s), longint'(eo_s));
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
        if (chk_on) compare_all();
    endtask

    task automatic clear_all();
        clr = 1'b1; cycle(); clr = 1'b0;
    endtask

    task automatic snap_now();
        snap = 1'b1; cycle(); snap = 1'b0;
    endtask

    task automatic do_read(input int s, output longint dw, output longint ds,
                           output bit ow, output bit os);
        sel = SW'(s); rrd = 1'b1;
        cycle();
        chk("read_resp_pulse", longint'(resp_w), 1);
        dw = longint'(rdat_w); ds = longint'(rdat_s); ow = rovf_w; os = rovf_s;
        rrd = 1'b0;
        cycle();
        chk("read_resp_drop", longint'(resp_w), 0);
    endtask

    typedef struct {
        int        ch;
        bit        mode;
        bit        en;
        int        len;
        bit [15:0] pat;
        int        exp;
    } vec_t;

    vec_t   vecs [6];
    longint dw, ds;
    bit     ow, os;
    bit     pat_bit;
    bit     held [4];

    initial begin
        n_cmp = 0; n_err = 0; chk_on = 0;
        rst = 1'b0; ev = '0; md = '0; en = 1'b0; clr = 1'b0; snap = 1'b0; rrd = 1'b0; sel = '0;

        vecs[0] = '{ch: 0, mode: 1'b0, en: 1'b1, len: 10, pat: 16'h03FF, exp: 10};
        vecs[1] = '{ch: 1, mode: 1'b1, en: 1'b1, len: 7,  pat: 16'h006B, exp: 3};
        vecs[2] = '{ch: 1, mode: 1'b1, en: 1'b0, len: 7,  pat: 16'h006B, exp: 0};
        vecs[3] = '{ch: 2, mode: 1'b0, en: 1'b0, len: 6,  pat: 16'h003F, exp: 0};
        vecs[4] = '{ch: 5, mode: 1'b0, en: 1'b1, len: 8,  pat: 16'h00B5, exp: 5};
        vecs[5] = '{ch: 4, mode: 1'b1, en: 1'b1, len: 8,  pat: 16'h00B5, exp: 4};

        cycle();
        chk_on = 1;
        cycle();
        chk("reset_resp", longint'(resp_w), 0);
        chk("reset_rdata", longint'(rdat_w), 0);
        chk("reset_overflow", longint'(ovf_s), 0);
        rst = 1'b1;
        cycle();

        // Table-driven single-channel counts.
        for (int v = 0; v < 6; v++) begin
            clear_all();
            md = '0; md[vecs[v].ch] = vecs[v].mode; en = vecs[v].en;
            for (int j = 0; j < vecs[v].len; j++) begin
                pat_bit = vecs[v].pat[j];
                ev = '0; ev[vecs[v].ch] = pat_bit;
                cycle();
            end
            ev = '0; en = 1'b1;
            snap_now();
            do_read(vecs[v].ch, dw, ds, ow, os);
            chk("vec_rdata_wrap", dw, longint'(vecs[v].exp));
            chk("vec_rdata_sat", ds, longint'(vecs[v].exp));
            chk("vec_rovf", longint'(ow), 0);
        end

        // 257 level events on an 8-bit channel: wrap vs saturate.
        clear_all();
        md = '0; en = 1'b1; ev = '0; ev[3] = 1'b1;
        for (int j = 0; j < 257; j++) begin
            cycle();
            if (j == 254) chk("ovf_before_wrap", longint'(ovf_w[3]), 0);
            if (j == 255) begin
                chk("ovf_at_wrap_w", longint'(ovf_w[3]), 1);
                chk("ovf_at_wrap_s", longint'(ovf_s[3]), 1);
            end
        end
        ev = '0;
        snap_now();
        do_read(3, dw, ds, ow, os);
        chk("wrap_cnt", dw, 1);
        chk("wrap_ovf", longint'(ow), 1);
        chk("sat_cnt", ds, 255);
        chk("sat_ovf", longint'(os), 1);

        // Read-and-clear with a lost same-cycle event.
        clear_all();
        chk("clear_drops_ovf", longint'(ovf_w), 0);
        ev[2] = 1'b1;
        repeat (5) cycle();
        snap = 1'b1; clr = 1'b1;
        cycle();
        snap = 1'b0; clr = 1'b0; ev = '0;
        do_read(2, dw, ds, ow, os);
        chk("rc_shadow", dw, 5);
        do_read(6, dw, ds, ow, os);
        chk("bad_sel_rdata", dw, 0);
        chk("bad_sel_rovf", longint'(ow), 0);
        do_read(7, dw, ds, ow, os);
        chk("bad_sel7_rdata", ds, 0);
        snap_now();
        do_read(2, dw, ds, ow, os);
        chk("rc_live_zero", dw, 0);

        // Snapshot during RESP must not disturb returned data.
        clear_all();
        ev[0] = 1'b1; repeat (4) cycle(); ev = '0;
        snap_now();
        ev[0] = 1'b1; repeat (3) cycle(); ev = '0;
        sel = SW'(0); rrd = 1'b1;
        cycle();
        chk("resp_snap_data", longint'(rdat_w), 4);
        rrd = 1'b0; snap = 1'b1;
        cycle();
        snap = 1'b0;
        chk("resp_snap_hold", longint'(rdat_w), 4);
        do_read(0, dw, ds, ow, os);
        chk("resp_snap_next", dw, 7);

        // rd_read held four cycles gives two responses two cycles apart.
        rrd = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cycle();
            held[j] = resp_w;
        end
        rrd = 1'b0;
        chk("held_r0", longint'(held[0]), 1);
        chk("held_r1", longint'(held[1]), 0);
        chk("held_r2", longint'(held[2]), 1);
        chk("held_r3", longint'(held[3]), 0);
        cycle();
        chk("held_after", longint'(resp_w), 0);

        // Randomized traffic against the model.
        for (int j = 0; j < 400; j++) begin
            if (j % 50 == 0) md = NC'($urandom);
            ev   = NC'($urandom);
            en   = ($urandom_range(0, 7) != 0);
            clr  = ($urandom_range(0, 31) == 0);
            snap = ($urandom_range(0, 5) == 0);
            rrd  = ($urandom_range(0, 2) == 0);
            sel  = SW'($urandom_range(0, 7));
            cycle();
        end
        ev = '0; en = 1'b1; clr = 1'b0; snap = 1'b0; rrd = 1'b0; md = '0;

        // Reset in RESP, then edge-mode behaviour around reset release and enable.
        ev[0] = 1'b1; repeat (3) cycle(); ev = '0;
        snap_now();
        sel = SW'(0); rrd = 1'b1;
        cycle();
        chk("pre_reset_resp", longint'(resp_w), 1);
        rrd = 1'b0; rst = 1'b0; md[4] = 1'b1; ev[4] = 1'b1;
        cycle();
        chk("rst_resp", longint'(resp_w), 0);
        chk("rst_rdata", longint'(rdat_w), 0);
        chk("rst_overflow", longint'(ovf_w), 0);
        cycle();
        rst = 1'b1;
        repeat (3) cycle();
        do_read(0, dw, ds, ow, os);
        chk("post_rst_read", dw, 0);
        snap_now();
        do_read(4, dw, ds, ow, os);
        chk("edge_held_rst", dw, 0);
        ev[4] = 1'b0; cycle();
        ev[4] = 1'b1; cycle();
        ev[4] = 1'b0;
        snap_now();
        do_read(4, dw, ds, ow, os);
        chk("edge_after_low", dw, 1);

        clear_all();
        md[5] = 1'b1; en = 1'b0; ev[5] = 1'b1;
        repeat (2) cycle();
        en = 1'b1;
        repeat (3) cycle();
        ev = '0;
        snap_now();
        do_read(5, dw, ds, ow, os);
        chk("edge_held_enable", dw, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
